axi4_lite_slv_reg_file: RTL and testbench
=========================================

Name: axi4_lite_slv_reg_file

Overview:
- AXI4-Lite responder (slave end) that terminates `axi4_lite_if.slv_port` and implements a bank of NUM_REGS read/write registers.
- Register contents are exported flat to fabric logic.
- Serves as the DUT for UVM register-model trials, driven by the master clocking block.

Parameters:
- ADDR_BIT_WIDTH, 32, address width; must match the bound interface.
- DATA_BIT_WIDTH, 32, data width; 32 or 64 only.
- NUM_REGS, 8, number of registers; ≥1.
- RST_VAL, '0, reset value of every register (DATA_BIT_WIDTH bits).

Ports:
- clk  input  1  clock; same net as the interface clk.
- rst_n  input  1  asynchronous active-low reset.
- axi  modport  -  axi4_lite_if.slv_port, AXI4-Lite responder side.
- regs_q  output  NUM_REGS*DATA_BIT_WIDTH  register contents; reg i is at bits [i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH].

Behaviour:
- Reset (async assert, sync release inside block):
  - awready, wready, bvalid, arready, rvalid = 0.
  - bresp, rresp = OKAY; rdata = 0.
  - All registers = RST_VAL.
  - Reset mid-transaction discards any captured address/data and pending responses.
- First edge after reset release: awready = wready = arready = 1.
- Decode:
  - BYTE_OFS = log2(DATA_BIT_WIDTH/8); index = addr >> BYTE_OFS; low BYTE_OFS bits ignored.
  - index ≥ NUM_REGS means unmapped.
  - awprot and arprot are ignored.
- Write channel, FSM W_ADDR_DATA -> W_RESP:
  - AW and W are accepted independently and in either order.
  - On an AW handshake (awvalid & awready): latch awaddr; awready = 0 next cycle.
  - On a W handshake: latch wdata and wstrb; wready = 0 next cycle.
  - At the edge ending the cycle in which the second of the two handshakes completes (both may complete in the same cycle):
    - Commit the write: byte k of the register is updated iff wstrb[k].
    - Set bvalid = 1 and drive bresp; FSM -> W_RESP.
  - W_RESP holds bvalid and bresp stable until bready.
  - The edge after bvalid & bready: bvalid = 0, awready = wready = 1; FSM -> W_ADDR_DATA.
  - wstrb = 0 completes normally with OKAY and changes nothing.
- Read channel, FSM R_ADDR -> R_DATA:
  - On an AR handshake at cycle T:
    - T+1: rvalid = 1; rdata = register value as sampled at T; arready = 0.
    - rdata and rresp are held until rready.
  - The edge after rvalid & rready: rvalid = 0, arready = 1.
  - Throughput: one read per 2 cycles minimum when rready is held high.
- Simultaneous events:
  - Read and write channels are fully independent.
  - A read of register X whose AR handshake falls in the write-commit cycle of X returns the old value.
- Handshake rules:
  - Ready is never withdrawn without a handshake.
  - valid/data outputs are registered and stable while valid & !ready.

Optional Feature:
- Macro: AXI4_LITE_SLV_REG_FILE_DECERR_EN.
- Defined:
  - An unmapped write is ignored and answered with bresp = DECERR (2'b11).
  - An unmapped read returns rdata = 0 with rresp = DECERR.
- Undefined:
  - Unmapped writes are ignored and reads return 0, both with OKAY.
  - No error response is ever generated.

Decomposition:
- Package axi4_lite_pkg holds:
  - axi4_resp_t enum (OKAY/EXOKAY/SLVERR/DECERR).
  - Write FSM state enum and read FSM state enum.
  - Function `strb_merge(old, new, strb)`.
- Natural sub-module: axi4_lite_slv_rd_ch, the read-channel FSM plus rdata mux.
- Write channel and register storage stay in the top module.

Test Plan:
1. Reset, then read reg 0..7 with RST_VAL=32'hA5A5_0000 -> every rdata = 32'hA5A5_0000, rresp = OKAY, rvalid one cycle after AR handshake.
2. AW then W three cycles later: addr 0x8, wdata 32'h1234_5678, wstrb 4'hF -> bvalid the cycle after the W handshake; regs_q reg2 = 32'h1234_5678.
3. Same-cycle AW+W to 0x4, wdata 32'hFFFF_FFFF, wstrb 4'b0101 over 32'h0 -> reg1 = 32'h00FF_00FF; bready held low for 5 cycles -> bvalid and bresp stable, awready = 0 throughout.
4. Write 0x1 to reg3 while a read AR to 0xC completes in the commit cycle -> read returns the old value; a following read returns 0x1.
5. Access to addr 0x40 (NUM_REGS=8) -> with macro: bresp/rresp = 2'b11, rdata = 0, registers unchanged; without macro: OKAY, rdata = 0.
6. Assert rst_n low while bvalid and rvalid are pending -> both drop asynchronously; all registers = RST_VAL; readies return to 1 one edge after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register-file slice.
package axi4_lite_pkg;

   localparam int MAX_DATA_W = 64;
   localparam int MAX_STRB_W = MAX_DATA_W / 8;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi4_resp_t;

   typedef enum logic {
      W_ADDR_DATA = 1'b0,
      W_RESP      = 1'b1
   } wr_state_t;

   typedef enum logic {
      R_ADDR = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Byte-lane merge sized for the widest supported bus; callers zero-extend.
   function automatic logic [MAX_DATA_W-1:0] strb_merge(
      input logic [MAX_DATA_W-1:0] old_val,
      input logic [MAX_DATA_W-1:0] new_val,
      input logic [MAX_STRB_W-1:0] strb
   );
      logic [MAX_DATA_W-1:0] res;
      res = old_val;
      for (int k = 0; k < MAX_STRB_W; k++) begin
         if (strb[k]) res[k*8 +: 8] = new_val[k*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with responder and requester views.
interface axi4_lite_if #(
   parameter int ADDR_BIT_WIDTH = 32,
   parameter int DATA_BIT_WIDTH = 32
) (
   input logic clk
);

   logic [ADDR_BIT_WIDTH-1:0]   awaddr;
   logic [2:0]                  awprot;
   logic                        awvalid;
   logic                        awready;
   logic [DATA_BIT_WIDTH-1:0]   wdata;
   logic [DATA_BIT_WIDTH/8-1:0] wstrb;
   logic                        wvalid;
   logic                        wready;
   logic [1:0]                  bresp;
   logic                        bvalid;
   logic                        bready;
   logic [ADDR_BIT_WIDTH-1:0]   araddr;
   logic [2:0]                  arprot;
   logic                        arvalid;
   logic                        arready;
   logic [DATA_BIT_WIDTH-1:0]   rdata;
   logic [1:0]                  rresp;
   logic                        rvalid;
   logic                        rready;

   modport slv_port (
      input  clk,
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid,    output wready,
      output bresp, bvalid,           input  bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid,    input  rready
   );

   modport mst_port (
      input  clk,
      output awaddr, awprot, awvalid, input  awready,
      output wdata, wstrb, wvalid,    input  wready,
      input  bresp, bvalid,           output bready,
      output araddr, arprot, arvalid, input  arready,
      input  rdata, rresp, rvalid,    output rready
   );

endinterface

// File: rtl/axi4_lite_slv_rd_ch.sv
// Read channel: AR capture, register mux and held R response.
// Build option AXI4_LITE_SLV_REG_FILE_DECERR_EN answers unmapped reads with DECERR.
//
// state  | meaning
// R_ADDR | arready high, waiting for an AR handshake
// R_DATA | rvalid high, rdata/rresp held until rready
module axi4_lite_slv_rd_ch
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_BIT_WIDTH = 32,
   parameter int DATA_BIT_WIDTH = 32,
   parameter int NUM_REGS       = 8
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_REGS*DATA_BIT_WIDTH-1:0] regs_q,
   input  logic [ADDR_BIT_WIDTH-1:0]          araddr,
   input  logic                               arvalid,
   input  logic                               rready,
   output logic                               arready,
   output logic                               rvalid,
   output logic [DATA_BIT_WIDTH-1:0]          rdata,
   output logic [1:0]                         rresp
);

   localparam int BYTE_OFS = $clog2(DATA_BIT_WIDTH / 8);

   rd_state_t                 rd_state_q;
   axi4_resp_t                rresp_q;
   logic [ADDR_BIT_WIDTH-1:0] rd_idx;
   logic                      rd_mapped;
   logic [DATA_BIT_WIDTH-1:0] rd_val;
   axi4_resp_t                rd_resp;

   // Decode the AR address and select the addressed register (zero when unmapped).
   always_comb begin
      rd_idx    = araddr >> BYTE_OFS;
      rd_mapped = (rd_idx < ADDR_BIT_WIDTH'(NUM_REGS));
      rd_val    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == ADDR_BIT_WIDTH'(i)) rd_val = regs_q[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      end
`ifdef AXI4_LITE_SLV_REG_FILE_DECERR_EN
      rd_resp = rd_mapped ? OKAY : DECERR;
`else
      rd_resp = OKAY;
`endif
   end

   // Read FSM; rdata is the register value seen in the AR handshake cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_state_q <= R_ADDR;
         arready    <= 1'b0;
         rvalid     <= 1'b0;
         rdata      <= '0;
         rresp_q    <= OKAY;
      end else begin
         case (rd_state_q)
            R_ADDR: begin
               if (arvalid && arready) begin
                  rdata      <= rd_mapped ? rd_val : '0;
                  rresp_q    <= rd_resp;
                  rvalid     <= 1'b1;
                  arready    <= 1'b0;
                  rd_state_q <= R_DATA;
               end else begin
                  arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (rready) begin
                  rvalid     <= 1'b0;
                  arready    <= 1'b1;
                  rd_state_q <= R_ADDR;
               end
            end
            default: rd_state_q <= R_ADDR;
         endcase
      end
   end

   assign rresp = rresp_q;

endmodule

// File: rtl/axi4_lite_slv_reg_file.sv
// AXI4-Lite responder with NUM_REGS byte-writable registers exported flat.
// Build option AXI4_LITE_SLV_REG_FILE_DECERR_EN answers unmapped accesses with DECERR.
//
// state       | meaning
// W_ADDR_DATA | collecting AW and W in either order
// W_RESP      | write committed, bvalid/bresp held until bready
module axi4_lite_slv_reg_file
   import axi4_lite_pkg::*;
#(
   parameter int                         ADDR_BIT_WIDTH = 32,
   parameter int                         DATA_BIT_WIDTH = 32,
   parameter int                         NUM_REGS       = 8,
   parameter logic [DATA_BIT_WIDTH-1:0]  RST_VAL        = '0
) (
   input  logic                               clk,
   input  logic                               rst_n,
   axi4_lite_if.slv_port                      axi,
   output logic [NUM_REGS*DATA_BIT_WIDTH-1:0] regs_q
);

   localparam int STRB_W   = DATA_BIT_WIDTH / 8;
   localparam int BYTE_OFS = $clog2(STRB_W);

   wr_state_t                 wr_state_q;
   logic                      awready_q;
   logic                      wready_q;
   logic                      bvalid_q;
   axi4_resp_t                bresp_q;
   logic                      aw_held_q;
   logic                      w_held_q;
   logic [ADDR_BIT_WIDTH-1:0] awaddr_q;
   logic [DATA_BIT_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]         wstrb_q;

   logic                      aw_hs;
   logic                      w_hs;
   logic                      wr_commit;
   logic [ADDR_BIT_WIDTH-1:0] wr_addr;
   logic [DATA_BIT_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]         wr_strb;
   logic [ADDR_BIT_WIDTH-1:0] wr_idx;
   logic                      wr_mapped;
   axi4_resp_t                wr_resp;
   logic [DATA_BIT_WIDTH-1:0] wr_old;
   logic [DATA_BIT_WIDTH-1:0] wr_merged;
   logic [MAX_DATA_W-1:0]     old_ext;
   logic [MAX_DATA_W-1:0]     new_ext;
   logic [MAX_STRB_W-1:0]     strb_ext;
   logic [MAX_DATA_W-1:0]     merged_ext;
   logic                      unused_ok;

   assign aw_hs = axi.awvalid & awready_q;
   assign w_hs  = axi.wvalid & wready_q;
   // Commit fires in the cycle the later of the two handshakes lands.
   assign wr_commit = (wr_state_q == W_ADDR_DATA) && (aw_hs || aw_held_q) && (w_hs || w_held_q);

   // Pick live or latched AW/W fields, decode, and build the byte-merged word.
   always_comb begin
      wr_addr   = aw_hs ? axi.awaddr : awaddr_q;
      wr_data   = w_hs ? axi.wdata : wdata_q;
      wr_strb   = w_hs ? axi.wstrb : wstrb_q;
      wr_idx    = wr_addr >> BYTE_OFS;
      wr_mapped = (wr_idx < ADDR_BIT_WIDTH'(NUM_REGS));
`ifdef AXI4_LITE_SLV_REG_FILE_DECERR_EN
      wr_resp   = wr_mapped ? OKAY : DECERR;
`else
      wr_resp   = OKAY;
`endif
      wr_old = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_idx == ADDR_BIT_WIDTH'(i)) wr_old = regs_q[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      end
      old_ext                       = '0;
      old_ext[DATA_BIT_WIDTH-1:0]   = wr_old;
      new_ext                       = '0;
      new_ext[DATA_BIT_WIDTH-1:0]   = wr_data;
      strb_ext                      = '0;
      strb_ext[STRB_W-1:0]          = wr_strb;
      merged_ext                    = strb_merge(old_ext, new_ext, strb_ext);
      wr_merged                     = merged_ext[DATA_BIT_WIDTH-1:0];
   end

   // Write FSM: independent AW/W capture, commit, then hold B until bready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q <= W_ADDR_DATA;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= OKAY;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
      end else begin
         case (wr_state_q)
            W_ADDR_DATA: begin
               if (aw_hs) awaddr_q <= axi.awaddr;
               if (w_hs) begin
                  wdata_q <= axi.wdata;
                  wstrb_q <= axi.wstrb;
               end
               if (wr_commit) begin
                  bvalid_q   <= 1'b1;
                  bresp_q    <= wr_resp;
                  awready_q  <= 1'b0;
                  wready_q   <= 1'b0;
                  aw_held_q  <= 1'b0;
                  w_held_q   <= 1'b0;
                  wr_state_q <= W_RESP;
               end else begin
                  aw_held_q <= aw_held_q | aw_hs;
                  w_held_q  <= w_held_q | w_hs;
                  awready_q <= ~(aw_held_q | aw_hs);
                  wready_q  <= ~(w_held_q | w_hs);
               end
            end
            W_RESP: begin
               if (axi.bready) begin
                  bvalid_q   <= 1'b0;
                  awready_q  <= 1'b1;
                  wready_q   <= 1'b1;
                  wr_state_q <= W_ADDR_DATA;
               end
            end
            default: wr_state_q <= W_ADDR_DATA;
         endcase
      end
   end

   // Register storage; unmapped commits leave every register untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= {NUM_REGS{RST_VAL}};
      end else if (wr_commit && wr_mapped) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == ADDR_BIT_WIDTH'(i)) regs_q[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH] <= wr_merged;
         end
      end
   end

   assign axi.awready = awready_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = bresp_q;

   axi4_lite_slv_rd_ch #(
      .ADDR_BIT_WIDTH (ADDR_BIT_WIDTH),
      .DATA_BIT_WIDTH (DATA_BIT_WIDTH),
      .NUM_REGS       (NUM_REGS)
   ) u_rd_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .regs_q  (regs_q),
      .araddr  (axi.araddr),
      .arvalid (axi.arvalid),
      .rready  (axi.rready),
      .arready (axi.arready),
      .rvalid  (axi.rvalid),
      .rdata   (axi.rdata),
      .rresp   (axi.rresp)
   );

   // Protection bits are not decoded; the interface clock is the same net as clk.
   assign unused_ok = ^{axi.awprot, axi.arprot, axi.clk, merged_ext};

endmodule

// File: tb/tb_axi4_lite_slv_reg_file.sv
// Directed bench for axi4_lite_slv_reg_file (8 x 32-bit, reset value A5A5_0000).
module tb_axi4_lite_slv_reg_file;

   localparam int          AW = 32;
   localparam int          DW = 32;
   localparam int          NR = 8;
   localparam logic [31:0] RV = 32'hA5A5_0000;
`ifdef AXI4_LITE_SLV_REG_FILE_DECERR_EN
   localparam logic [1:0]  UNMAP_RESP = 2'b11;
`else
   localparam logic [1:0]  UNMAP_RESP = 2'b00;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR*DW-1:0]  regs_q;
   logic [31:0]       model [NR];
   int                checks = 0;
   int                errors = 0;

   axi4_lite_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) axi_if (.clk(clk));

   axi4_lite_slv_reg_file #(
      .ADDR_BIT_WIDTH (AW),
      .DATA_BIT_WIDTH (DW),
      .NUM_REGS       (NR),
      .RST_VAL        (RV)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .axi    (axi_if),
      .regs_q (regs_q)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic sel_flag(input int sel);
      case (sel)
         0:       return axi_if.awready;
         1:       return axi_if.wready;
         2:       return axi_if.arready;
         3:       return axi_if.bvalid;
         default: return axi_if.rvalid;
      endcase
   endfunction

   task automatic wait_flag(input int sel, input string tag);
      int   n;
      logic f;
      n = 0;
      f = sel_flag(sel);
      while (!f && n < 20) begin
         @(negedge clk);
         n++;
         f = sel_flag(sel);
      end
      check_val(tag, 64'(f), 64'd1);
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NR; i++) check_val(tag, 64'(regs_q[i*DW +: DW]), 64'(model[i]));
   endtask

   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      @(negedge clk);
      axi_if.awaddr  = addr;
      axi_if.awvalid = 1'b1;
      axi_if.wdata   = data;
      axi_if.wstrb   = strb;
      axi_if.wvalid  = 1'b1;
      wait_flag(0, "wr_awready");
      wait_flag(1, "wr_wready");
      @(negedge clk);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      wait_flag(3, "wr_bvalid");
      resp = axi_if.bresp;
      axi_if.bready = 1'b1;
      @(negedge clk);
      axi_if.bready = 1'b0;
   endtask

   task automatic read_txn(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic rv_next);
      @(negedge clk);
      axi_if.araddr  = addr;
      axi_if.arvalid = 1'b1;
      wait_flag(2, "rd_arready");
      @(negedge clk);
      axi_if.arvalid = 1'b0;
      rv_next = axi_if.rvalid;
      wait_flag(4, "rd_rvalid");
      data = axi_if.rdata;
      resp = axi_if.rresp;
      axi_if.rready = 1'b1;
      @(negedge clk);
      axi_if.rready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rsp;
      logic        rv1;

      axi_if.awaddr  = '0;
      axi_if.awprot  = '0;
      axi_if.awvalid = 1'b0;
      axi_if.wdata   = '0;
      axi_if.wstrb   = '0;
      axi_if.wvalid  = 1'b0;
      axi_if.bready  = 1'b0;
      axi_if.araddr  = '0;
      axi_if.arprot  = '0;
      axi_if.arvalid = 1'b0;
      axi_if.rready  = 1'b0;
      for (int i = 0; i < NR; i++) model[i] = RV;

      // Reset values
      repeat (2) @(negedge clk);
      check_val("rst_awready", 64'(axi_if.awready), 64'd0);
      check_val("rst_wready",  64'(axi_if.wready),  64'd0);
      check_val("rst_arready", 64'(axi_if.arready), 64'd0);
      check_val("rst_bvalid",  64'(axi_if.bvalid),  64'd0);
      check_val("rst_rvalid",  64'(axi_if.rvalid),  64'd0);
      check_val("rst_bresp",   64'(axi_if.bresp),   64'd0);
      check_val("rst_rresp",   64'(axi_if.rresp),   64'd0);
      check_val("rst_rdata",   64'(axi_if.rdata),   64'd0);
      check_regs("rst_regs");
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rel_awready", 64'(axi_if.awready), 64'd1);
      check_val("rel_wready",  64'(axi_if.wready),  64'd1);
      check_val("rel_arready", 64'(axi_if.arready), 64'd1);

      // Read every register after reset
      for (int i = 0; i < NR; i++) begin
         read_txn(32'(i * 4), rd, rsp, rv1);
         check_val("t1_rdata", 64'(rd), 64'(RV));
         check_val("t1_rresp", 64'(rsp), 64'd0);
         check_val("t1_rv_lat", 64'(rv1), 64'd1);
      end

      // AW first, W three cycles later
      @(negedge clk);
      axi_if.awaddr  = 32'h8;
      axi_if.awvalid = 1'b1;
      @(negedge clk);
      axi_if.awvalid = 1'b0;
      check_val("t2_awready_low", 64'(axi_if.awready), 64'd0);
      check_val("t2_bvalid_early", 64'(axi_if.bvalid), 64'd0);
      repeat (2) @(negedge clk);
      check_val("t2_wready", 64'(axi_if.wready), 64'd1);
      axi_if.wdata  = 32'h1234_5678;
      axi_if.wstrb  = 4'hF;
      axi_if.wvalid = 1'b1;
      @(negedge clk);
      axi_if.wvalid = 1'b0;
      model[2] = 32'h1234_5678;
      check_val("t2_bvalid", 64'(axi_if.bvalid), 64'd1);
      check_val("t2_bresp",  64'(axi_if.bresp),  64'd0);
      check_val("t2_reg2",   64'(regs_q[2*DW +: DW]), 64'h1234_5678);
      axi_if.bready = 1'b1;
      @(negedge clk);
      axi_if.bready = 1'b0;
      check_val("t2_bvalid_clr", 64'(axi_if.bvalid), 64'd0);
      check_val("t2_awready_ret", 64'(axi_if.awready), 64'd1);

      // Same-cycle AW+W partial strobe over zero, B held off for 5 cycles
      write_txn(32'h4, 32'h0, 4'hF, rsp);
      model[1] = 32'h0;
      check_val("t3_pre_resp", 64'(rsp), 64'd0);
      @(negedge clk);
      axi_if.awaddr  = 32'h4;
      axi_if.awvalid = 1'b1;
      axi_if.wdata   = 32'hFFFF_FFFF;
      axi_if.wstrb   = 4'b0101;
      axi_if.wvalid  = 1'b1;
      @(negedge clk);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      model[1] = 32'h00FF_00FF;
      check_val("t3_reg1", 64'(regs_q[1*DW +: DW]), 64'h00FF_00FF);
      for (int c = 0; c < 5; c++) begin
         check_val("t3_bvalid_hold", 64'(axi_if.bvalid), 64'd1);
         check_val("t3_bresp_hold", 64'(axi_if.bresp), 64'd0);
         check_val("t3_awready_low", 64'(axi_if.awready), 64'd0);
         check_val("t3_wready_low", 64'(axi_if.wready), 64'd0);
         @(negedge clk);
      end
      axi_if.bready = 1'b1;
      @(negedge clk);
      axi_if.bready = 1'b0;
      check_val("t3_bvalid_clr", 64'(axi_if.bvalid), 64'd0);

      // Zero strobe changes nothing
      write_txn(32'h8, 32'hFFFF_FFFF, 4'h0, rsp);
      check_val("strb0_resp", 64'(rsp), 64'd0);
      check_regs("strb0_regs");

      // Read of reg3 in its own commit cycle returns the old value
      @(negedge clk);
      axi_if.awaddr  = 32'hC;
      axi_if.awvalid = 1'b1;
      axi_if.wdata   = 32'h1;
      axi_if.wstrb   = 4'hF;
      axi_if.wvalid  = 1'b1;
      axi_if.araddr  = 32'hC;
      axi_if.arvalid = 1'b1;
      @(negedge clk);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      axi_if.arvalid = 1'b0;
      model[3] = 32'h1;
      check_val("t4_bvalid", 64'(axi_if.bvalid), 64'd1);
      check_val("t4_rvalid", 64'(axi_if.rvalid), 64'd1);
      check_val("t4_rdata_old", 64'(axi_if.rdata), 64'(RV));
      check_val("t4_reg3", 64'(regs_q[3*DW +: DW]), 64'h1);
      axi_if.bready = 1'b1;
      axi_if.rready = 1'b1;
      @(negedge clk);
      axi_if.bready = 1'b0;
      axi_if.rready = 1'b0;
      check_val("t4_rvalid_clr", 64'(axi_if.rvalid), 64'd0);
      check_val("t4_arready_ret", 64'(axi_if.arready), 64'd1);
      read_txn(32'hC, rd, rsp, rv1);
      check_val("t4_rdata_new", 64'(rd), 64'h1);
      read_txn(32'hE, rd, rsp, rv1);
      check_val("lowbits_rdata", 64'(rd), 64'h1);
      read_txn(32'h1C, rd, rsp, rv1);
      check_val("last_reg_rdata", 64'(rd), 64'(RV));
      check_val("last_reg_rresp", 64'(rsp), 64'd0);

      // Unmapped accesses
      write_txn(32'h40, 32'hDEAD_BEEF, 4'hF, rsp);
      check_val("t5_bresp", 64'(rsp), 64'(UNMAP_RESP));
      check_regs("t5_regs");
      read_txn(32'h40, rd, rsp, rv1);
      check_val("t5_rdata", 64'(rd), 64'd0);
      check_val("t5_rresp", 64'(rsp), 64'(UNMAP_RESP));
      read_txn(32'h20, rd, rsp, rv1);
      check_val("t5_edge_rdata", 64'(rd), 64'd0);
      check_val("t5_edge_rresp", 64'(rsp), 64'(UNMAP_RESP));

      // Reset with B and R pending
      @(negedge clk);
      axi_if.awaddr  = 32'h0;
      axi_if.awvalid = 1'b1;
      axi_if.wdata   = 32'h1111_1111;
      axi_if.wstrb   = 4'hF;
      axi_if.wvalid  = 1'b1;
      axi_if.araddr  = 32'h4;
      axi_if.arvalid = 1'b1;
      @(negedge clk);
      axi_if.awvalid = 1'b0;
      axi_if.wvalid  = 1'b0;
      axi_if.arvalid = 1'b0;
      check_val("t6_bvalid_pend", 64'(axi_if.bvalid), 64'd1);
      check_val("t6_rvalid_pend", 64'(axi_if.rvalid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) model[i] = RV;
      check_val("t6_bvalid_rst", 64'(axi_if.bvalid), 64'd0);
      check_val("t6_rvalid_rst", 64'(axi_if.rvalid), 64'd0);
      check_val("t6_awready_rst", 64'(axi_if.awready), 64'd0);
      check_val("t6_arready_rst", 64'(axi_if.arready), 64'd0);
      check_regs("t6_regs");
      @(negedge clk);
      rst_n = 1'b1;
      check_val("t6_awready_rel", 64'(axi_if.awready), 64'd0);
      @(negedge clk);
      check_val("t6_awready_1", 64'(axi_if.awready), 64'd1);
      check_val("t6_wready_1",  64'(axi_if.wready),  64'd1);
      check_val("t6_arready_1", 64'(axi_if.arready), 64'd1);
      read_txn(32'h0, rd, rsp, rv1);
      check_val("t6_rdata", 64'(rd), 64'(RV));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
